// File: rtl/match_capture_if.sv
// Bus bundle for match_capture: config writes, the (key, data) beat stream and the read port.
// The master drives config/stream/read requests; the slave returns read responses and capture flags.
interface match_capture_if #(
   parameter int KEY_W    = 4,
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   logic [KEY_W-1:0]    cfg_key;
   logic                cfg_en;
   logic                in_valid;
   logic [KEY_W-1:0]    in_key;
   logic [DATA_W-1:0]   in_data;
   logic                rd_en;
   logic [CH_W-1:0]     rd_ch;
   logic                rd_valid;
   logic [DATA_W-1:0]   rd_data;
   logic [CNT_W-1:0]    rd_hits;
   logic                rd_ovr;
   logic [CHANNELS-1:0] cap_valid;

   modport master (
      output cfg_we, cfg_ch, cfg_key, cfg_en, in_valid, in_key, in_data, rd_en, rd_ch,
      input  rd_valid, rd_data, rd_hits, rd_ovr, cap_valid
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_key, cfg_en, in_valid, in_key, in_data, rd_en, rd_ch,
      output rd_valid, rd_data, rd_hits, rd_ovr, cap_valid
   );
endinterface

// File: rtl/match_capture.sv
// Multi-channel key match and capture with saturating hit counters and sticky overrun flags.
// Capture lands one edge after the beat; reads answer one cycle later; no backpressure anywhere.
module match_capture #(
   parameter int KEY_W       = 4,
   parameter int DATA_W      = 32,
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 8,
   parameter int FIRST_MATCH = 0,
   parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input logic            clk,
   input logic            rst,
   match_capture_if.slave bus
);
   localparam logic [CNT_W-1:0] HITS_MAX = '1;

   logic [KEY_W-1:0]    key_q  [CHANNELS];
   logic [DATA_W-1:0]   data_q [CHANNELS];
   logic [CNT_W-1:0]    hits_q [CHANNELS];
   logic [CHANNELS-1:0] en_q;
   logic [CHANNELS-1:0] ovr_q;
   logic [CHANNELS-1:0] cap_q;

   logic [CHANNELS-1:0] hit_raw;
   logic [CHANNELS-1:0] take;
   logic [CHANNELS-1:0] rd_sel;
   logic [CHANNELS-1:0] cfg_sel;
   logic [DATA_W-1:0]   rd_data_mux;
   logic [CNT_W-1:0]    rd_hits_mux;
   logic                rd_ovr_mux;

   always_comb begin
      hit_raw     = '0;
      rd_sel      = '0;
      cfg_sel     = '0;
      rd_data_mux = '0;
      rd_hits_mux = '0;
      rd_ovr_mux  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         hit_raw[c] = bus.in_valid & en_q[c] & (bus.in_key == key_q[c]);
         rd_sel[c]  = bus.rd_en & (bus.rd_ch == CH_W'(c));
         cfg_sel[c] = bus.cfg_we & (bus.cfg_ch == CH_W'(c));
         // An out-of-range rd_ch selects nothing, so the response is all zeros.
         if (bus.rd_ch == CH_W'(c)) begin
            rd_data_mux = data_q[c];
            rd_hits_mux = hits_q[c];
            rd_ovr_mux  = ovr_q[c];
         end
      end
   end

   always_comb begin
      take = hit_raw;
      // Two's-complement trick keeps only the lowest set bit.
      if (FIRST_MATCH != 0) take = hit_raw & (~hit_raw + CHANNELS'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            key_q[c]  <= '0;
            data_q[c] <= '0;
            hits_q[c] <= '0;
         end
         en_q          <= '0;
         ovr_q         <= '0;
         cap_q         <= '0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
         bus.rd_hits   <= '0;
         bus.rd_ovr    <= 1'b0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (take[c]) begin
               data_q[c] <= bus.in_data;
               cap_q[c]  <= 1'b1;
               // A same-edge read has already snapshotted the old state, so restart from this beat.
               if (rd_sel[c]) begin
                  hits_q[c] <= CNT_W'(1);
                  ovr_q[c]  <= 1'b0;
               end else begin
                  if (hits_q[c] != HITS_MAX) hits_q[c] <= hits_q[c] + CNT_W'(1);
                  if (cap_q[c]) ovr_q[c] <= 1'b1;
               end
            end else if (rd_sel[c]) begin
               cap_q[c]  <= 1'b0;
               hits_q[c] <= '0;
               ovr_q[c]  <= 1'b0;
            end
            if (cfg_sel[c]) begin
               key_q[c] <= bus.cfg_key;
               en_q[c]  <= bus.cfg_en;
            end
         end
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= rd_data_mux;
            bus.rd_hits <= rd_hits_mux;
            bus.rd_ovr  <= rd_ovr_mux;
         end
      end
   end

   assign bus.cap_valid = cap_q;
endmodule

// File: tb/tb_match_capture.sv
// Bench for match_capture: two instances (all-match/8-bit counters/4 ch, first-match/2-bit counters/3 ch)
// share one stimulus stream; a reference model pushes expected read responses to per-instance queues.
module tb_match_capture;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   match_capture_if #(.KEY_W(4), .DATA_W(32), .CHANNELS(4), .CNT_W(8), .CH_W(2)) bus_a ();
   match_capture_if #(.KEY_W(4), .DATA_W(32), .CHANNELS(3), .CNT_W(2), .CH_W(2)) bus_b ();

   match_capture #(.KEY_W(4), .DATA_W(32), .CHANNELS(4), .CNT_W(8), .FIRST_MATCH(0)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   match_capture #(.KEY_W(4), .DATA_W(32), .CHANNELS(3), .CNT_W(2), .FIRST_MATCH(1)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   typedef struct {
      logic [31:0] data;
      int          hits;
      logic        ovr;
   } rsp_t;

   localparam int NCH  [2] = '{4, 3};
   localparam int FM   [2] = '{0, 1};
   localparam int HMAX [2] = '{255, 3};

   logic [3:0]  m_key  [2][4];
   logic        m_en   [2][4];
   logic [31:0] m_data [2][4];
   int          m_hits [2][4];
   logic        m_ovr  [2][4];
   logic        m_cap  [2][4];
   rsp_t        sb_q   [2][$];
   rsp_t        last   [2];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) begin
            m_key[d][c] = '0; m_en[d][c] = 1'b0; m_data[d][c] = '0;
            m_hits[d][c] = 0; m_ovr[d][c] = 1'b0; m_cap[d][c] = 1'b0;
         end
         sb_q[d].delete();
         last[d].data = '0; last[d].hits = 0; last[d].ovr = 1'b0;
      end
   endtask

   function automatic logic [63:0] cap_bits(input int d);
      logic [63:0] v = '0;
      for (int c = 0; c < NCH[d]; c++) v[c] = m_cap[d][c];
      return v;
   endfunction

   task automatic model_edge(input logic cwe, input int cch, input logic [3:0] ckey, input logic cen,
                             input logic iv, input logic [3:0] ik, input logic [31:0] id,
                             input logic re, input int rch);
      for (int d = 0; d < 2; d++) begin
         rsp_t r;
         logic tk [4];
         logic found = 1'b0;
         if (re) begin
            r.data = '0; r.hits = 0; r.ovr = 1'b0;
            if (rch < NCH[d]) begin
               r.data = m_data[d][rch]; r.hits = m_hits[d][rch]; r.ovr = m_ovr[d][rch];
            end
            sb_q[d].push_back(r);
         end
         for (int c = 0; c < 4; c++) begin
            tk[c] = 1'b0;
            if (c < NCH[d] && iv && m_en[d][c] && ik == m_key[d][c] && !(FM[d] != 0 && found)) begin
               tk[c] = 1'b1;
               found = 1'b1;
            end
         end
         for (int c = 0; c < NCH[d]; c++) begin
            logic rdc = re && (rch == c);
            if (tk[c]) begin
               if (rdc) begin
                  m_hits[d][c] = 1; m_ovr[d][c] = 1'b0;
               end else begin
                  if (m_hits[d][c] < HMAX[d]) m_hits[d][c]++;
                  if (m_cap[d][c]) m_ovr[d][c] = 1'b1;
               end
               m_data[d][c] = id;
               m_cap[d][c]  = 1'b1;
            end else if (rdc) begin
               m_cap[d][c] = 1'b0; m_hits[d][c] = 0; m_ovr[d][c] = 1'b0;
            end
         end
         if (cwe && cch < NCH[d]) begin
            m_key[d][cch] = ckey;
            m_en[d][cch]  = cen;
         end
      end
   endtask

   task automatic drive(input logic cwe, input int cch, input logic [3:0] ckey, input logic cen,
                        input logic iv, input logic [3:0] ik, input logic [31:0] id,
                        input logic re, input int rch);
      bus_a.cfg_we = cwe; bus_a.cfg_ch = 2'(cch); bus_a.cfg_key = ckey; bus_a.cfg_en = cen;
      bus_a.in_valid = iv; bus_a.in_key = ik; bus_a.in_data = id; bus_a.rd_en = re; bus_a.rd_ch = 2'(rch);
      bus_b.cfg_we = cwe; bus_b.cfg_ch = 2'(cch); bus_b.cfg_key = ckey; bus_b.cfg_en = cen;
      bus_b.in_valid = iv; bus_b.in_key = ik; bus_b.in_data = id; bus_b.rd_en = re; bus_b.rd_ch = 2'(rch);
   endtask

   task automatic check_outputs(input logic re);
      logic [63:0] o_v [2], o_d [2], o_h [2], o_o [2], o_c [2];
      o_v[0] = 64'(bus_a.rd_valid); o_d[0] = 64'(bus_a.rd_data); o_h[0] = 64'(bus_a.rd_hits);
      o_o[0] = 64'(bus_a.rd_ovr);   o_c[0] = 64'(bus_a.cap_valid);
      o_v[1] = 64'(bus_b.rd_valid); o_d[1] = 64'(bus_b.rd_data); o_h[1] = 64'(bus_b.rd_hits);
      o_o[1] = 64'(bus_b.rd_ovr);   o_c[1] = 64'(bus_b.cap_valid);
      for (int d = 0; d < 2; d++) begin
         string p = (d == 0) ? "a" : "b";
         chk_val({p, "_rd_valid"}, o_v[d], 64'(re));
         if (re) begin
            chk_val({p, "_sb_depth"}, 64'(sb_q[d].size()), 64'd1);
            if (sb_q[d].size() != 0) last[d] = sb_q[d].pop_front();
         end
         chk_val({p, "_rd_data"}, o_d[d], 64'(last[d].data));
         chk_val({p, "_rd_hits"}, o_h[d], 64'(last[d].hits));
         chk_val({p, "_rd_ovr"},  o_o[d], 64'(last[d].ovr));
         chk_val({p, "_cap_valid"}, o_c[d], cap_bits(d));
      end
   endtask

   task automatic step(input logic cwe, input int cch, input logic [3:0] ckey, input logic cen,
                       input logic iv, input logic [3:0] ik, input logic [31:0] id,
                       input logic re, input int rch);
      @(negedge clk);
      drive(cwe, cch, ckey, cen, iv, ik, id, re, rch);
      model_edge(cwe, cch, ckey, cen, iv, ik, id, re, rch);
      @(posedge clk);
      #1;
      check_outputs(re);
   endtask

   task automatic cfg(input int ch, input logic [3:0] k, input logic e);
      step(1'b1, ch, k, e, 1'b0, 4'd0, 32'd0, 1'b0, 0);
   endtask
   task automatic beat(input logic [3:0] k, input logic [31:0] d);
      step(1'b0, 0, 4'd0, 1'b0, 1'b1, k, d, 1'b0, 0);
   endtask
   task automatic rd(input int ch);
      step(1'b0, 0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, ch);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs(1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Basic capture and read-clear
      cfg(0, 4'd1, 1'b1);
      beat(4'd1, 32'hA5);
      rd(0);

      // Two channels share a key: all-match vs first-match
      cfg(0, 4'd3, 1'b1);
      cfg(2, 4'd3, 1'b1);
      beat(4'd3, 32'd7);
      rd(0);
      rd(2);

      // Overrun, then a clean second read
      cfg(0, 4'd1, 1'b1);
      beat(4'd1, 32'd1); beat(4'd1, 32'd2); beat(4'd1, 32'd3);
      rd(0);
      rd(0);

      // Hit counter saturation on the 2-bit instance
      for (int i = 0; i < 6; i++) beat(4'd1, 32'(100 + i));
      rd(0);

      // Same-edge capture and read
      beat(4'd1, 32'h11);
      step(1'b0, 0, 4'd0, 1'b0, 1'b1, 4'd1, 32'h55, 1'b1, 0);
      rd(0);

      // Out-of-range channel on the 3-channel instance
      cfg(3, 4'd5, 1'b1);
      beat(4'd5, 32'd9);
      rd(3);

      // Config write and match on one edge use the old key/enable
      step(1'b1, 1, 4'd6, 1'b1, 1'b1, 4'd6, 32'h66, 1'b0, 0);
      beat(4'd6, 32'h67);
      cfg(1, 4'd6, 1'b0);
      beat(4'd6, 32'h68);
      rd(1);

      // Back-to-back reads and a random mix
      rd(0); rd(1); rd(2); rd(3);
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
              32'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // Fill every channel, then async reset between edges with a beat and a read in flight
      for (int c = 0; c < 4; c++) cfg(c, 4'(c), 1'b1);
      for (int c = 0; c < 4; c++) beat(4'(c), 32'(32'h1000 + c));
      rd(1);
      beat(4'd1, 32'h2001);
      @(negedge clk);
      drive(1'b0, 0, 4'd0, 1'b0, 1'b1, 4'd0, 32'hDEAD, 1'b1, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_val("a_rst_rd_valid", 64'(bus_a.rd_valid), 64'd0);
      chk_val("a_rst_rd_data", 64'(bus_a.rd_data), 64'd0);
      chk_val("a_rst_rd_hits", 64'(bus_a.rd_hits), 64'd0);
      chk_val("a_rst_rd_ovr", 64'(bus_a.rd_ovr), 64'd0);
      chk_val("a_rst_cap_valid", 64'(bus_a.cap_valid), 64'd0);
      chk_val("b_rst_rd_valid", 64'(bus_b.rd_valid), 64'd0);
      chk_val("b_rst_rd_data", 64'(bus_b.rd_data), 64'd0);
      chk_val("b_rst_rd_hits", 64'(bus_b.rd_hits), 64'd0);
      chk_val("b_rst_cap_valid", 64'(bus_b.cap_valid), 64'd0);
      model_reset();
      @(negedge clk);
      drive(1'b0, 0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_outputs(1'b0);

      // All channels disabled after reset: key 0 must not capture
      beat(4'd0, 32'h77);
      rd(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
